logic_pipe: RTL and testbench
=============================

Name: logic_pipe

Overview:
- Parametrised, pipelined bitwise logic unit. It generalises the single-bit 2-input gate family (AND/OR/XOR/XNOR and friends) to WIDTH-bit operands.
- Adds a runtime op select, a valid/ready handshake, an accumulate mode and registered reduction flags.
- Sits between a stimulus/source block and any consumer that needs registered gate results, e.g. equality/parity checking in the lab datapaths.

Parameters:
WIDTH, 8, operand/result width in bits (>=1)

Ports:
clk  input  1  single clock; all state updates on the rising edge
rst  input  1  synchronous, active-high reset
in_valid  input  1  source presents a transaction
in_ready  output  1  block can accept a transaction this cycle
a  input  WIDTH  operand A
b  input  WIDTH  operand B (ignored when acc_en=1)
op  input  3  operation select
acc_en  input  1  use accumulator in place of b
acc_clr  input  1  clear the accumulator
out_valid  output  1  result valid
out_ready  input  1  consumer accepts the result
y  output  WIDTH  result
all_ones  output  1  reduction AND of y (equality flag under XNOR)
parity  output  1  reduction XOR of y

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Op codes:
  - 0 AND, 1 OR, 2 XOR, 3 XNOR, 4 NAND, 5 NOR
  - 6 NOT A (b unused)
  - 7 PASS A
- Operand select: opnd_b = acc_en ? acc : b.
- Handshakes:
  - Accept occurs when in_valid && in_ready.
  - Output transfer occurs when out_valid && out_ready.
- Result computation: on accept, the result r = f(op, a, opnd_b) is computed combinationally and captured into stage 1.
- Accumulator (acc, WIDTH bits):
  - Loads r on every accept.
  - acc_clr without accept: acc <= 0.
  - acc_clr with accept: the transaction uses opnd_b = 0 when acc_en=1, and acc <= r.
- Pipeline: two register stages, s1 and s2.
  - s1 holds {r, valid}.
  - s2 holds {y, all_ones, parity, valid}. Reductions are computed from s1.r when it moves into s2.
- Advance rules:
  - s2 loads from s1 when !s2.valid || out_ready.
  - s1 loads when !s1.valid || s2 loads.
  - in_ready = !s1.valid || s2 loads. This path is combinational from out_ready.
- Latency and throughput:
  - Accept in cycle N gives out_valid=1 in cycle N+2 when unstalled.
  - Sustained throughput is 1 transaction/cycle.
- Backpressure:
  - While out_valid && !out_ready, y, all_ones and parity hold stable.
  - At most 2 transactions are in flight. in_ready=0 when both stages are full and out_ready=0.
  - No drop, no duplicate, order preserved.
- A transfer on the output and an accept on the input in the same cycle are both honoured; occupancy is unchanged.
- in_valid=0 cycles create bubbles. Bubbles collapse when downstream is stalled.
- Reset values: s1.valid=0, s2.valid=0, y=0, all_ones=0, parity=0, acc=0, out_valid=0.
  - in_ready=1 in the first cycle after reset.
  - rst overrides any concurrent accept, transfer or acc_clr.
- Reset mid-operation: all in-flight transactions are discarded and nothing is emitted.
- Width rules:
  - No carries, purely bitwise.
  - For WIDTH=1, all_ones=y and parity=y.
- No X-propagation: a and b are only sampled on accept.

Decomposition:
- Package logic_pipe_pkg: op code localparams OP_AND..OP_PASSA (3 bits), and an s2 struct type/width constant if used.
- Sub-module logic_op_core, combinational: (op, a, opnd_b) -> r, parametrised by WIDTH. It is reusable by the single-gate benches.
- Pipeline registers, handshake and accumulator stay in logic_pipe.

Test Plan (WIDTH=8):
1. Hold rst=1 for 2 cycles, release. Required response:
   - out_valid=0, y=8'h00, in_ready=1.
   - First XOR with acc_en=1, a=8'h3C returns y=8'h3C, proving acc=0.
2. Gate truth sweep, out_ready=1: a=8'h03, b=8'h05, op=0..7 on consecutive cycles. Required response, in order, with each result 2 cycles after its accept:
   - y = 01, 07, 06, F9, FE, F8, FC, 03
3. Equality check: op=3 (XNOR), a=b=8'hA5. Required response:
   - y=8'hFF, all_ones=1, parity=0.
   - Then a=8'hA5, b=8'hA4: y=8'hFE, all_ones=0, parity=1.
4. Backpressure: out_ready=0, then offer 3 back-to-back transactions. Required response:
   - 2 accepted, and in_ready=0 on the third.
   - y holds stable while stalled.
   - Raise out_ready: results emerge in order, the third is then accepted, and none is lost.
5. Accumulate: pulse acc_clr, then op=2 with acc_en=1 and a=8'h0F, then a=8'hF0, then a=8'hFF. Required response: y = 0F, FF, 00.
   - Also pulse acc_clr concurrent with an accept: that transaction uses opnd_b=0.
6. Reset mid-operation: two transactions in flight with out_ready=0, assert rst for 1 cycle. Required response:
   - Next cycle out_valid=0 and in_ready=1.
   - Neither stale result is ever emitted.
   - acc=0, verified as in scenario 1.

Source files
------------

// File: rtl/logic_pipe_pkg.sv
// Shared definitions for the pipelined bitwise logic unit.
package logic_pipe_pkg;

  localparam int unsigned OP_W = 3;

  localparam logic [OP_W-1:0] OP_AND   = 3'd0;
  localparam logic [OP_W-1:0] OP_OR    = 3'd1;
  localparam logic [OP_W-1:0] OP_XOR   = 3'd2;
  localparam logic [OP_W-1:0] OP_XNOR  = 3'd3;
  localparam logic [OP_W-1:0] OP_NAND  = 3'd4;
  localparam logic [OP_W-1:0] OP_NOR   = 3'd5;
  localparam logic [OP_W-1:0] OP_NOTA  = 3'd6;
  localparam logic [OP_W-1:0] OP_PASSA = 3'd7;

endpackage

// File: rtl/logic_pipe_if.sv
// Source/consumer handshake bundle for logic_pipe.
interface logic_pipe_if
  import logic_pipe_pkg::*;
#(
  parameter int unsigned WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [OP_W-1:0]  op;
  logic             acc_en;
  logic             acc_clr;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] y;
  logic             all_ones;
  logic             parity;

  modport master (
    output in_valid, a, b, op, acc_en, acc_clr, out_ready,
    input  in_ready, out_valid, y, all_ones, parity
  );

  modport slave (
    input  in_valid, a, b, op, acc_en, acc_clr, out_ready,
    output in_ready, out_valid, y, all_ones, parity
  );
endinterface

// File: rtl/logic_op_core.sv
// Combinational WIDTH-bit 2-input gate family selected by op.
module logic_op_core
  import logic_pipe_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic [OP_W-1:0]  op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] opnd_b,
  output logic [WIDTH-1:0] r
);

  always_comb begin
    r = '0;
    case (op)
      OP_AND:   r = a & opnd_b;
      OP_OR:    r = a | opnd_b;
      OP_XOR:   r = a ^ opnd_b;
      OP_XNOR:  r = ~(a ^ opnd_b);
      OP_NAND:  r = ~(a & opnd_b);
      OP_NOR:   r = ~(a | opnd_b);
      OP_NOTA:  r = ~a;
      OP_PASSA: r = a;
      default:  r = '0;
    endcase
  end

endmodule

// File: rtl/logic_pipe.sv
// Two-stage valid/ready pipelined logic unit with accumulator and
// registered reduction flags on the output stage.
module logic_pipe
  import logic_pipe_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic         clk,
  input  logic         rst,
  logic_pipe_if.slave  bus
);

  logic             s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0] s1_r_q, s1_r_d;
  logic             s2_valid_q, s2_valid_d;
  logic [WIDTH-1:0] s2_y_q, s2_y_d;
  logic             s2_all_ones_q, s2_all_ones_d;
  logic             s2_parity_q, s2_parity_d;
  logic [WIDTH-1:0] acc_q, acc_d;

  logic             s2_load;
  logic             s1_load;
  logic             accept;
  logic [WIDTH-1:0] opnd_b;
  logic [WIDTH-1:0] r;

  assign s2_load = !s2_valid_q || bus.out_ready;
  assign s1_load = !s1_valid_q || s2_load;
  assign accept  = bus.in_valid && s1_load;
  // A clear arriving with an accumulate transaction zeroes the operand itself.
  assign opnd_b  = bus.acc_en ? (bus.acc_clr ? '0 : acc_q) : bus.b;

  logic_op_core #(.WIDTH(WIDTH)) u_core (
    .op     (bus.op),
    .a      (bus.a),
    .opnd_b (opnd_b),
    .r      (r)
  );

  always_comb begin
    s1_valid_d    = s1_valid_q;
    s1_r_d        = s1_r_q;
    s2_valid_d    = s2_valid_q;
    s2_y_d        = s2_y_q;
    s2_all_ones_d = s2_all_ones_q;
    s2_parity_d   = s2_parity_q;
    acc_d         = acc_q;

    if (s2_load) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_y_d        = s1_r_q;
        s2_all_ones_d = &s1_r_q;
        s2_parity_d   = ^s1_r_q;
      end
    end

    if (s1_load) begin
      s1_valid_d = accept;
      if (accept) s1_r_d = r;
    end

    if (accept) acc_d = r;
    else if (bus.acc_clr) acc_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q    <= 1'b0;
      s1_r_q        <= '0;
      s2_valid_q    <= 1'b0;
      s2_y_q        <= '0;
      s2_all_ones_q <= 1'b0;
      s2_parity_q   <= 1'b0;
      acc_q         <= '0;
    end else begin
      s1_valid_q    <= s1_valid_d;
      s1_r_q        <= s1_r_d;
      s2_valid_q    <= s2_valid_d;
      s2_y_q        <= s2_y_d;
      s2_all_ones_q <= s2_all_ones_d;
      s2_parity_q   <= s2_parity_d;
      acc_q         <= acc_d;
    end
  end

  assign bus.in_ready  = s1_load;
  assign bus.out_valid = s2_valid_q;
  assign bus.y         = s2_y_q;
  assign bus.all_ones  = s2_all_ones_q;
  assign bus.parity    = s2_parity_q;

endmodule

// File: tb/tb_logic_pipe.sv
// Bench for logic_pipe (WIDTH=8): directed scenarios plus a randomized stream,
// all results predicted from per-bit gate truth tables and a transaction queue.
module tb_logic_pipe;

  localparam int unsigned W = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic_pipe_if #(.WIDTH(W)) bus ();

  logic_pipe #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [7:0] r;
    int         cyc;
  } item_t;

  item_t      q[$];
  logic [7:0] macc = '0;
  int         cyc = 0;
  int         last_stall = -1;
  logic       prev_stall = 1'b0;
  logic [7:0] prev_y;
  logic       prev_ao, prev_par;

  // Gate defined by its 4-entry truth table indexed by {a_bit, b_bit}.
  function automatic logic [7:0] model_op(input logic [2:0] op, input logic [7:0] a,
                                          input logic [7:0] b);
    logic [3:0] tt;
    logic [7:0] res;
    case (op)
      3'd0:    tt = 4'b1000;
      3'd1:    tt = 4'b1110;
      3'd2:    tt = 4'b0110;
      3'd3:    tt = 4'b1001;
      3'd4:    tt = 4'b0111;
      3'd5:    tt = 4'b0001;
      3'd6:    tt = 4'b0011;
      default: tt = 4'b1100;
    endcase
    for (int i = 0; i < 8; i++) res[i] = tt[{a[i], b[i]}];
    return res;
  endfunction

  // Scoreboard: ordering, data, flags, occupancy-based ready, hold, latency.
  always @(negedge clk) begin : monitor
    logic       exp_ready;
    logic [7:0] opb, res;
    item_t      it;
    if (rst) begin
      q.delete();
      macc       = '0;
      prev_stall = 1'b0;
      last_stall = cyc;
    end else begin
      exp_ready = (q.size() < 2) || bus.out_ready;
      tests++;
      if (bus.in_ready !== exp_ready) begin
        fails++;
        $display("FAIL in_ready cyc=%0d got=%b exp=%b", cyc, bus.in_ready, exp_ready);
      end
      if (prev_stall) begin
        tests++;
        if ({bus.out_valid, bus.y, bus.all_ones, bus.parity} !== {1'b1, prev_y, prev_ao, prev_par}) begin
          fails++;
          $display("FAIL hold cyc=%0d got v=%b y=%h exp v=1 y=%h", cyc, bus.out_valid, bus.y, prev_y);
        end
      end
      if (q.size() == 0) begin
        tests++;
        if (bus.out_valid !== 1'b0) begin
          fails++;
          $display("FAIL spurious_out cyc=%0d got out_valid=%b y=%h exp out_valid=0", cyc, bus.out_valid, bus.y);
        end
      end else begin
        if (q[0].cyc > last_stall && cyc <= q[0].cyc + 2) begin
          tests++;
          if (bus.out_valid !== (cyc == q[0].cyc + 2)) begin
            fails++;
            $display("FAIL latency cyc=%0d accepted=%0d got out_valid=%b exp=%b", cyc, q[0].cyc,
                     bus.out_valid, (cyc == q[0].cyc + 2));
          end
        end
        if (bus.out_valid === 1'b1 && bus.out_ready) begin
          it = q.pop_front();
          tests++;
          if ({bus.y, bus.all_ones, bus.parity} !== {it.r, &it.r, ^it.r}) begin
            fails++;
            $display("FAIL data cyc=%0d got y=%h ao=%b par=%b exp y=%h ao=%b par=%b", cyc,
                     bus.y, bus.all_ones, bus.parity, it.r, &it.r, ^it.r);
          end
        end
      end
      if (bus.in_valid && exp_ready) begin
        opb = bus.acc_en ? (bus.acc_clr ? 8'h00 : macc) : bus.b;
        res = model_op(bus.op, bus.a, opb);
        q.push_back('{r: res, cyc: cyc});
        macc = res;
      end else if (bus.acc_clr) begin
        macc = '0;
      end
      prev_stall = (bus.out_valid === 1'b1) && !bus.out_ready;
      prev_y     = bus.y;
      prev_ao    = bus.all_ones;
      prev_par   = bus.parity;
      if (!bus.out_ready) last_stall = cyc;
    end
    cyc++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                       input logic ae, input logic ac);
    bus.in_valid = 1'b1;
    bus.op       = op;
    bus.a        = a;
    bus.b        = b;
    bus.acc_en   = ae;
    bus.acc_clr  = ac;
  endtask

  task automatic idle();
    bus.in_valid = 1'b0;
    bus.acc_clr  = 1'b0;
    bus.acc_en   = 1'($urandom);
    bus.op       = 3'($urandom);
    bus.a        = 8'($urandom);
    bus.b        = 8'($urandom);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle();
    bus.out_ready = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    @(negedge clk);
    tests++;
    if ({bus.out_valid, bus.y, bus.in_ready} !== {1'b0, 8'h00, 1'b1}) begin
      fails++;
      $display("FAIL reset_state got v=%b y=%h rdy=%b exp v=0 y=00 rdy=1", bus.out_valid, bus.y, bus.in_ready);
    end
    tick();
    drive(3'd2, 8'h3C, 8'($urandom), 1'b1, 1'b0);
    tick();
    idle();
    tick();
    @(negedge clk);
    tests++;
    if ({bus.out_valid, bus.y} !== {1'b1, 8'h3C}) begin
      fails++;
      $display("FAIL reset_acc got v=%b y=%h exp v=1 y=3c", bus.out_valid, bus.y);
    end
    tick();
  endtask

  task automatic test_truth_sweep();
    logic [7:0] exp_tt[8] = '{8'h01, 8'h07, 8'h06, 8'hF9, 8'hFE, 8'hF8, 8'hFC, 8'h03};
    bus.out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (i < 8) drive(3'(i), 8'h03, 8'h05, 1'b0, 1'b0);
      else idle();
      @(negedge clk);
      if (i >= 2) begin
        tests++;
        if ({bus.out_valid, bus.y} !== {1'b1, exp_tt[i-2]}) begin
          fails++;
          $display("FAIL truth op=%0d got v=%b y=%h exp v=1 y=%h", i - 2, bus.out_valid, bus.y, exp_tt[i-2]);
        end
      end
      tick();
    end
  endtask

  task automatic test_equality();
    bus.out_ready = 1'b1;
    drive(3'd3, 8'hA5, 8'hA5, 1'b0, 1'b0);
    tick();
    drive(3'd3, 8'hA5, 8'hA4, 1'b0, 1'b0);
    tick();
    idle();
    @(negedge clk);
    tests++;
    if ({bus.out_valid, bus.y, bus.all_ones, bus.parity} !== {1'b1, 8'hFF, 1'b1, 1'b0}) begin
      fails++;
      $display("FAIL equal got y=%h ao=%b par=%b exp y=ff ao=1 par=0", bus.y, bus.all_ones, bus.parity);
    end
    tick();
    @(negedge clk);
    tests++;
    if ({bus.out_valid, bus.y, bus.all_ones, bus.parity} !== {1'b1, 8'hFE, 1'b0, 1'b1}) begin
      fails++;
      $display("FAIL unequal got y=%h ao=%b par=%b exp y=fe ao=0 par=1", bus.y, bus.all_ones, bus.parity);
    end
    tick();
  endtask

  task automatic test_backpressure();
    logic [2:0] ops[3];
    logic [7:0] as[3], bs[3], exp_r[3];
    logic [7:0] got[$];
    for (int k = 0; k < 3; k++) begin
      ops[k]   = 3'($urandom);
      as[k]    = 8'($urandom);
      bs[k]    = 8'($urandom);
      exp_r[k] = model_op(ops[k], as[k], bs[k]);
    end
    bus.out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      drive(ops[k], as[k], bs[k], 1'b0, 1'b0);
      @(negedge clk);
      tests++;
      if (bus.in_ready !== (k < 2)) begin
        fails++;
        $display("FAIL bp_ready txn=%0d got=%b exp=%b", k, bus.in_ready, (k < 2));
      end
      tick();
    end
    for (int h = 0; h < 3; h++) begin
      @(negedge clk);
      tests++;
      if ({bus.in_ready, bus.out_valid, bus.y} !== {1'b0, 1'b1, exp_r[0]}) begin
        fails++;
        $display("FAIL bp_stall got rdy=%b v=%b y=%h exp rdy=0 v=1 y=%h", bus.in_ready, bus.out_valid,
                 bus.y, exp_r[0]);
      end
      tick();
    end
    bus.out_ready = 1'b1;
    for (int j = 0; j < 8; j++) begin
      @(negedge clk);
      if (j == 0) begin
        tests++;
        if (bus.in_ready !== 1'b1) begin
          fails++;
          $display("FAIL bp_release got rdy=%b exp rdy=1", bus.in_ready);
        end
      end
      if (bus.out_valid === 1'b1) got.push_back(bus.y);
      tick();
      if (j == 0) idle();
    end
    tests++;
    if (got.size() != 3) begin
      fails++;
      $display("FAIL bp_count got=%0d exp=3", got.size());
    end else begin
      for (int k = 0; k < 3; k++) begin
        tests++;
        if (got[k] !== exp_r[k]) begin
          fails++;
          $display("FAIL bp_order idx=%0d got=%h exp=%h", k, got[k], exp_r[k]);
        end
      end
    end
  endtask

  task automatic test_accumulate();
    logic [7:0] av[6]  = '{8'h0F, 8'hF0, 8'hFF, 8'h5A, 8'h33, 8'h00};
    logic       clr[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [7:0] ev[6]  = '{8'h0F, 8'hFF, 8'h00, 8'h5A, 8'h33, 8'h33};
    bus.out_ready = 1'b1;
    idle();
    bus.acc_clr = 1'b1;
    tick();
    for (int i = 0; i < 8; i++) begin
      if (i < 6) drive(3'd2, av[i], 8'($urandom), 1'b1, clr[i]);
      else idle();
      @(negedge clk);
      if (i >= 2) begin
        tests++;
        if ({bus.out_valid, bus.y} !== {1'b1, ev[i-2]}) begin
          fails++;
          $display("FAIL acc step=%0d got v=%b y=%h exp v=1 y=%h", i - 2, bus.out_valid, bus.y, ev[i-2]);
        end
      end
      tick();
    end
  endtask

  task automatic test_reset_mid();
    int seen = 0;
    bus.out_ready = 1'b0;
    drive(3'd7, 8'h81, 8'($urandom), 1'b0, 1'b0);
    tick();
    drive(3'd7, 8'h7E, 8'($urandom), 1'b0, 1'b0);
    tick();
    idle();
    @(negedge clk);
    tests++;
    if ({bus.out_valid, bus.in_ready} !== 2'b10) begin
      fails++;
      $display("FAIL mid_full got v=%b rdy=%b exp v=1 rdy=0", bus.out_valid, bus.in_ready);
    end
    tick();
    rst = 1'b1;
    bus.out_ready = 1'b1;
    bus.acc_clr = 1'b1;
    tick();
    rst = 1'b0;
    bus.acc_clr = 1'b0;
    @(negedge clk);
    tests++;
    if ({bus.out_valid, bus.in_ready, bus.y} !== {1'b0, 1'b1, 8'h00}) begin
      fails++;
      $display("FAIL mid_reset got v=%b rdy=%b y=%h exp v=0 rdy=1 y=00", bus.out_valid, bus.in_ready, bus.y);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      @(negedge clk);
      if (bus.out_valid === 1'b1) seen++;
    end
    tests++;
    if (seen != 0) begin
      fails++;
      $display("FAIL mid_stale got=%0d outputs exp=0", seen);
    end
    tick();
    drive(3'd2, 8'h3C, 8'($urandom), 1'b1, 1'b0);
    tick();
    idle();
    tick();
    @(negedge clk);
    tests++;
    if ({bus.out_valid, bus.y} !== {1'b1, 8'h3C}) begin
      fails++;
      $display("FAIL mid_acc got v=%b y=%h exp v=1 y=3c", bus.out_valid, bus.y);
    end
    tick();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      bus.in_valid  = ($urandom % 4) != 0;
      bus.out_ready = ($urandom % 3) != 0;
      bus.op        = 3'($urandom);
      bus.a         = 8'($urandom);
      bus.b         = 8'($urandom);
      bus.acc_en    = 1'($urandom);
      bus.acc_clr   = ($urandom % 8) == 0;
      tick();
    end
    idle();
    bus.out_ready = 1'b1;
    repeat (4) tick();
    @(negedge clk);
    tests++;
    if (q.size() != 0 || bus.out_valid !== 1'b0) begin
      fails++;
      $display("FAIL drain got pending=%0d v=%b exp pending=0 v=0", q.size(), bus.out_valid);
    end
    tick();
  endtask

  initial begin
    rst = 1'b1;
    bus.out_ready = 1'b1;
    idle();
    test_reset();
    test_truth_sweep();
    test_equality();
    test_backpressure();
    test_accumulate();
    test_reset_mid();
    test_random();
    repeat (2) tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
